// File: rtl/reg_file_pkg.sv
// Shared types and constants for the multi-port register file.
// Imported by reg_file_mp and reg_scoreboard.
package reg_file_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins.
// Lookups mask out registers being written back this cycle.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int DEPTH  = 32,
  parameter  int NREAD  = 2,
  parameter  int NWRITE = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_set_en,
  input  logic [AW-1:0]        i_set_addr,
  input  logic [NWRITE-1:0]    i_wr_en,
  input  logic [NWRITE*AW-1:0] i_wr_addr,
  input  logic [NREAD*AW-1:0]  i_rd_addr,
  output logic [NREAD-1:0]     o_busy
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_nxt;

  always_comb begin
    w_nxt = r_busy;
    for (int j = 0; j < NWRITE; j++) begin
      if (i_wr_en[j]) w_nxt[i_wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (i_set_en && i_set_addr != AW'(ZERO_REG))
      w_nxt[i_set_addr] = 1'b1;
    if (i_clr) w_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_nxt;
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit;
    assign w_ra = i_rd_addr[gi*AW +: AW];
    always_comb begin
      w_hit = 1'b0;
      for (int j = 0; j < NWRITE; j++) begin
        if (i_wr_en[j] && i_wr_addr[j*AW +: AW] == w_ra)
          w_hit = 1'b1;
      end
    end
    assign o_busy[gi] = r_busy[w_ra] & ~w_hit;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write bypass, busy
// scoreboard and a hardware clear sequencer; x0 reads zero.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int DEPTH  = 32,
  parameter  int NREAD  = 2,
  parameter  int NWRITE = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_req,
  output logic                   ready,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   wa,
  input  logic [NWRITE*XLEN-1:0] wd,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr
);

  state_e          r_state;
  state_e          w_nxt_state;
  logic [AW-1:0]   r_clr_ptr;
  logic [AW-1:0]   w_nxt_ptr;
  logic [XLEN-1:0] r_mem [DEPTH];

  logic              w_run;
  logic              w_wr_ok;
  logic [NWRITE-1:0] w_we;
  logic [NREAD-1:0]  w_sb_busy;

  assign w_run   = (r_state == RUN);
  // a clear request in RUN drops that cycle's writes and issues
  assign w_wr_ok = w_run & ~clr_req;
  assign w_we    = we & {NWRITE{w_wr_ok}};
  assign ready   = w_run;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_clr_ptr;
    unique case (r_state)
      CLEAR: begin
        w_nxt_ptr = r_clr_ptr + AW'(1);
        if (r_clr_ptr == AW'(DEPTH-1)) w_nxt_state = RUN;
      end
      RUN: begin
        if (clr_req) begin
          w_nxt_state = CLEAR;
          w_nxt_ptr   = AW'(1);
        end
      end
      default: w_nxt_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= AW'(1);
    end else begin
      r_state   <= w_nxt_state;
      r_clr_ptr <= w_nxt_ptr;
    end
  end

  // storage is deliberately not reset; the clear sequencer zeroes it
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_clr_ptr] <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (w_we[j] && wa[j*AW +: AW] != AW'(ZERO_REG))
          r_mem[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      end
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;
    assign w_ra = rd_addr[gi*AW +: AW];
    always_comb begin
      w_rd = r_mem[w_ra];
      for (int j = 0; j < NWRITE; j++) begin
        if (w_we[j] && wa[j*AW +: AW] == w_ra)
          w_rd = wd[j*XLEN +: XLEN];
      end
      if (!w_run || w_ra == AW'(ZERO_REG)) w_rd = '0;
    end
    assign rd_data[gi*XLEN +: XLEN] = w_rd;
    assign rd_busy[gi] = w_run & w_sb_busy[gi];
  end

  reg_scoreboard #(
    .DEPTH  (DEPTH),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_run & clr_req),
    .i_set_en   (iss_en & w_wr_ok),
    .i_set_addr (iss_addr),
    .i_wr_en    (w_we),
    .i_wr_addr  (wa),
    .i_rd_addr  (rd_addr),
    .o_busy     (w_sb_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard-driven bench for reg_file_mp: expected values are
// queued when stimulus is driven and popped at sample time.
module tb_reg_file_mp;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   clr_req = 1'b0;
  logic                   ready;
  logic [NREAD*AW-1:0]    rd_addr = '0;
  logic [NREAD*XLEN-1:0]  rd_data;
  logic [NREAD-1:0]       rd_busy;
  logic [NWRITE-1:0]      we = '0;
  logic [NWRITE*AW-1:0]   wa = '0;
  logic [NWRITE*XLEN-1:0] wd = '0;
  logic                   iss_en = 1'b0;
  logic [AW-1:0]          iss_addr = '0;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] q_exp[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  reg_file_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  task automatic idle();
    we = '0; wa = '0; wd = '0;
    iss_en = 1'b0; iss_addr = '0; clr_req = 1'b0;
  endtask

  task automatic drv();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    we[p] = 1'b1;
    wa[p*AW +: AW] = AW'(a);
    wd[p*XLEN +: XLEN] = d;
  endtask

  task automatic wait_ready(input string nm);
    int cnt;
    cnt = 0;
    q_exp.push_back(32'd31);
    smp();
    while (ready !== 1'b1 && cnt < 100) begin
      cnt++;
      smp();
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if (32'(cnt) !== exp_v) begin
      n_mis++;
      $display("FAIL %s: ready low %0d cycles, want %0d", nm, cnt, exp_v);
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    rd_addr[0 +: AW] = AW'(5);
    rd_addr[AW +: AW] = AW'(7);
    repeat (3) begin
      drv();
      q_exp.push_back(32'd0);
      smp();
      exp_v = q_exp.pop_front(); n_cmp++;
      if ({ready, rd_busy, rd_data} !== {35'd0}) begin
        n_mis++;
        $display("FAIL reset_out: ready=%b busy=%b data=%h want 0",
                 ready, rd_busy, rd_data);
      end
    end
    drv();
    rst_n = 1'b1;
    wait_ready("reset_ready_len");
    for (int a = 1; a < DEPTH; a += 2) begin
      drv();
      rd_addr[0 +: AW] = AW'(a);
      rd_addr[AW +: AW] = AW'(a + 1);
      q_exp.push_back(32'd0);
      q_exp.push_back(32'd0);
      smp();
      for (int i = 0; i < NREAD; i++) begin
        exp_v = q_exp.pop_front(); n_cmp++;
        if (rd_data[i*XLEN +: XLEN] !== exp_v) begin
          n_mis++;
          $display("FAIL reset_zero x%0d: got %h want %h",
                   a + i, rd_data[i*XLEN +: XLEN], exp_v);
        end
      end
    end
  endtask

  task automatic test_bypass();
    drv(); idle();
    wr(0, 5, 32'hDEADBEEF);
    rd_addr[0 +: AW] = AW'(5);
    q_exp.push_back(32'hDEADBEEF);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (rd_data[31:0] !== exp_v) begin
      n_mis++;
      $display("FAIL bypass_same: got %h want %h", rd_data[31:0], exp_v);
    end
    drv(); idle();
    q_exp.push_back(32'hDEADBEEF);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (rd_data[31:0] !== exp_v) begin
      n_mis++;
      $display("FAIL bypass_stored: got %h want %h", rd_data[31:0], exp_v);
    end
  endtask

  task automatic test_priority();
    drv(); idle();
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    rd_addr[AW +: AW] = AW'(7);
    q_exp.push_back(32'h22);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (rd_data[63:32] !== exp_v) begin
      n_mis++;
      $display("FAIL prio_bypass: got %h want %h", rd_data[63:32], exp_v);
    end
    drv(); idle();
    q_exp.push_back(32'h22);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (rd_data[63:32] !== exp_v) begin
      n_mis++;
      $display("FAIL prio_stored: got %h want %h", rd_data[63:32], exp_v);
    end
  endtask

  task automatic test_zero();
    drv(); idle();
    wr(1, 0, 32'hFFFFFFFF);
    iss_en = 1'b1;
    iss_addr = '0;
    rd_addr[0 +: AW] = '0;
    q_exp.push_back(32'd0);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (rd_data[31:0] !== exp_v) begin
      n_mis++;
      $display("FAIL x0_bypass: got %h want %h", rd_data[31:0], exp_v);
    end
    drv(); idle();
    q_exp.push_back(32'd0);
    q_exp.push_back(32'd0);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (rd_data[31:0] !== exp_v) begin
      n_mis++;
      $display("FAIL x0_stored: got %h want %h", rd_data[31:0], exp_v);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if (32'(rd_busy[0]) !== exp_v) begin
      n_mis++;
      $display("FAIL x0_busy: got %b want %0d", rd_busy[0], exp_v);
    end
  endtask

  task automatic test_busy();
    logic [31:0] seq [4];
    seq[0] = 32'd1; seq[1] = 32'd0; seq[2] = 32'd1; seq[3] = 32'd0;
    drv(); idle();
    iss_en = 1'b1; iss_addr = AW'(9);
    rd_addr[AW +: AW] = AW'(9);
    drv(); idle();
    q_exp.push_back(seq[0]);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (32'(rd_busy[1]) !== exp_v) begin
      n_mis++;
      $display("FAIL busy_after_iss: got %b want %0d", rd_busy[1], exp_v);
    end
    drv(); idle();
    wr(0, 9, 32'h99);
    iss_en = 1'b1; iss_addr = AW'(9);
    q_exp.push_back(seq[1]);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (32'(rd_busy[1]) !== exp_v) begin
      n_mis++;
      $display("FAIL busy_wb_mask: got %b want %0d", rd_busy[1], exp_v);
    end
    drv(); idle();
    q_exp.push_back(seq[2]);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (32'(rd_busy[1]) !== exp_v) begin
      n_mis++;
      $display("FAIL busy_set_wins: got %b want %0d", rd_busy[1], exp_v);
    end
    drv(); idle();
    wr(1, 9, 32'h9A);
    drv(); idle();
    q_exp.push_back(seq[3]);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (32'(rd_busy[1]) !== exp_v) begin
      n_mis++;
      $display("FAIL busy_cleared: got %b want %0d", rd_busy[1], exp_v);
    end
  endtask

  task automatic test_clear();
    drv(); idle();
    wr(0, 3, 32'h55);
    drv(); idle();
    rd_addr[0 +: AW] = AW'(3);
    rd_addr[AW +: AW] = AW'(12);
    q_exp.push_back(32'h55);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (rd_data[31:0] !== exp_v) begin
      n_mis++;
      $display("FAIL clr_pre_x3: got %h want %h", rd_data[31:0], exp_v);
    end
    drv(); idle();
    clr_req = 1'b1;
    q_exp.push_back(32'd1);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (32'(ready) !== exp_v) begin
      n_mis++;
      $display("FAIL clr_req_cycle: ready=%b want %0d", ready, exp_v);
    end
    for (int c = 0; c < 10; c++) begin
      drv(); idle();
      wr(0, 3, 32'h77);
      iss_en = 1'b1; iss_addr = AW'(12);
      q_exp.push_back(32'd0);
      smp();
      exp_v = q_exp.pop_front(); n_cmp++;
      if ({31'd0, ready} !== exp_v || rd_data[31:0] !== 32'd0
          || rd_busy !== 2'b00) begin
        n_mis++;
        $display("FAIL clr_active c%0d: ready=%b d=%h busy=%b want 0",
                 c, ready, rd_data[31:0], rd_busy);
      end
    end
    drv(); idle();
    rst_n = 1'b0;
    q_exp.push_back(32'd0);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (32'(ready) !== exp_v) begin
      n_mis++;
      $display("FAIL clr_rst_ready: ready=%b want %0d", ready, exp_v);
    end
    drv();
    rst_n = 1'b1;
    wait_ready("clr_restart_len");
    drv(); idle();
    q_exp.push_back(32'd0);
    q_exp.push_back(32'd0);
    smp();
    exp_v = q_exp.pop_front(); n_cmp++;
    if (rd_data[31:0] !== exp_v) begin
      n_mis++;
      $display("FAIL clr_post_x3: got %h want %h", rd_data[31:0], exp_v);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if (32'(rd_busy[1]) !== exp_v) begin
      n_mis++;
      $display("FAIL clr_post_busy: got %b want %0d", rd_busy[1], exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_priority();
    test_zero();
    test_busy();
    test_clear();
    if (q_exp.size() != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL queue_drain: %0d left want 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
